// File: rtl/parallel_in_serial_out_piso_tx_8_bit_if.sv
// Load handshake and serial-side signals of the PISO transmitter.
// master = word source / line observer, slave = the transmitter.
interface parallel_in_serial_out_piso_tx_8_bit_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Load_Valid_In;
  logic                  Load_Ready_Out;
  logic                  Serial_Data_Out;
  logic                  Frame_Out;
  logic                  Busy_Out;
  logic                  Done_Out;

  modport master (
    output Parallel_Data_In,
    output Load_Valid_In,
    input  Load_Ready_Out,
    input  Serial_Data_Out,
    input  Frame_Out,
    input  Busy_Out,
    input  Done_Out
  );

  modport slave (
    input  Parallel_Data_In,
    input  Load_Valid_In,
    output Load_Ready_Out,
    output Serial_Data_Out,
    output Frame_Out,
    output Busy_Out,
    output Done_Out
  );
endinterface

// File: rtl/parallel_in_serial_out_piso_tx_8_bit.sv
// LSB-first parallel-to-serial transmitter with valid/ready load and back-to-back
// reload on the last bit; bits change on posedge for a negedge-sampling receiver.
module parallel_in_serial_out_piso_tx_8_bit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input logic Clk_In,
  input logic Reset_In,
  parallel_in_serial_out_piso_tx_8_bit_if.slave bus_if
);
  localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ser_q, ser_d;
  logic                  frame_q, frame_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic last_bit;
  logic ready;
  logic accept;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
  assign ready    = (state_q == ST_IDLE) || last_bit;
  assign accept   = bus_if.Load_Valid_In && ready;

  // shift_q[0] is always the bit currently on the line
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = last_bit;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shift_d = bus_if.Parallel_Data_In;
      ser_d   = bus_if.Parallel_Data_In[0];
      frame_d = 1'b1;
      busy_d  = 1'b1;
    end else if (last_bit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ser_d   = IDLE_LEVEL;
      frame_d = 1'b0;
      busy_d  = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      cnt_d   = cnt_q + CNT_ONE;
      shift_d = shift_q >> 1;
      ser_d   = shift_q[1];
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Word storage needs no reset: it is only read while in SHIFT, which requires a load
  always_ff @(posedge Clk_In) begin
    shift_q <= shift_d;
  end

  assign bus_if.Load_Ready_Out  = ready;
  assign bus_if.Serial_Data_Out = ser_q;
  assign bus_if.Frame_Out       = frame_q;
  assign bus_if.Busy_Out        = busy_q;
  assign bus_if.Done_Out        = done_q;
endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx_8_bit.sv
// Directed bench for the PISO transmitter with a negedge SIPO receiver model
// feeding a scoreboard of expected words.
module tb_parallel_in_serial_out_piso_tx_8_bit;
  logic clk;
  logic rst;
  logic clk_en;

  parallel_in_serial_out_piso_tx_8_bit_if #(.DATA_WIDTH(8)) bus ();

  parallel_in_serial_out_piso_tx_8_bit #(
    .DATA_WIDTH(8),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .Clk_In  (clk),
    .Reset_In(rst),
    .bus_if  (bus)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic [7:0] sipo;
  int         nbits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample at negedge like the receiver and score complete words
  task automatic tick();
    logic [7:0] w;
    @(negedge clk);
    if (bus.Frame_Out === 1'b1) begin
      sipo  = {bus.Serial_Data_Out, sipo[7:1]};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        chk("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("sb_word", 32'(sipo), 32'(w));
        end
      end
    end else begin
      nbits = 0;
    end
  endtask

  int frames;

  initial begin
    total  = 0;
    bad    = 0;
    nbits  = 0;
    sipo   = '0;
    clk_en = 1'b0;
    rst    = 1'b0;
    bus.Load_Valid_In    = 1'b0;
    bus.Parallel_Data_In = 8'h00;

    // 1: reset with no clock running
    #1 rst = 1'b1;
    #1;
    chk("rst_line",  32'(bus.Serial_Data_Out), 32'd0);
    chk("rst_frame", 32'(bus.Frame_Out),       32'd0);
    chk("rst_busy",  32'(bus.Busy_Out),        32'd0);
    chk("rst_done",  32'(bus.Done_Out),        32'd0);
    chk("rst_ready", 32'(bus.Load_Ready_Out),  32'd1);
    clk_en = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();

    // 2: 0xA5 from IDLE
    bus.Parallel_Data_In = 8'hA5;
    bus.Load_Valid_In    = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    bus.Load_Valid_In = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a5;
      a5 = 8'hA5;
      chk("a5_line",  32'(bus.Serial_Data_Out), 32'(a5[k]));
      chk("a5_frame", 32'(bus.Frame_Out),       32'd1);
      chk("a5_busy",  32'(bus.Busy_Out),        32'd1);
      chk("a5_done",  32'(bus.Done_Out),        32'd0);
      chk("a5_ready", 32'(bus.Load_Ready_Out),  32'(k == 7));
      if (k < 7) tick();
    end
    tick();
    chk("a5_done_pulse", 32'(bus.Done_Out),        32'd1);
    chk("a5_end_frame",  32'(bus.Frame_Out),       32'd0);
    chk("a5_end_line",   32'(bus.Serial_Data_Out), 32'd0);
    chk("a5_end_ready",  32'(bus.Load_Ready_Out),  32'd1);
    chk("a5_end_busy",   32'(bus.Busy_Out),        32'd0);
    tick();
    chk("a5_done_single", 32'(bus.Done_Out), 32'd0);

    // 3: 0x5A looped into the receiver model
    bus.Parallel_Data_In = 8'h5A;
    bus.Load_Valid_In    = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    bus.Load_Valid_In = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    chk("sipo_5a", 32'(sipo), 32'h5A);
    tick();
    chk("5a_done", 32'(bus.Done_Out), 32'd1);

    // 4: valid held, 0x3C then 0xC3 back-to-back
    bus.Parallel_Data_In = 8'h3C;
    bus.Load_Valid_In    = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    frames = (bus.Frame_Out === 1'b1) ? 1 : 0;
    bus.Parallel_Data_In = 8'hC3;
    exp_q.push_back(8'hC3);
    for (int i = 1; i < 16; i++) begin
      tick();
      if (bus.Frame_Out === 1'b1) frames++;
      chk("b2b_done", 32'(bus.Done_Out), 32'(i == 8));
      if (i == 8) bus.Load_Valid_In = 1'b0;
    end
    chk("b2b_frames", 32'(frames), 32'd16);
    tick();
    chk("b2b_done_end",  32'(bus.Done_Out),  32'd1);
    chk("b2b_frame_end", 32'(bus.Frame_Out), 32'd0);

    // 5: valid during bit 3 of 0x00 is ignored; data toggling has no effect
    bus.Parallel_Data_In = 8'h00;
    bus.Load_Valid_In    = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    bus.Load_Valid_In    = 1'b0;
    bus.Parallel_Data_In = 8'hFF;
    for (int k = 1; k < 4; k++) tick();
    bus.Load_Valid_In = 1'b1;
    #1;
    chk("ign_ready_bit3", 32'(bus.Load_Ready_Out), 32'd0);
    for (int k = 4; k < 8; k++) begin
      tick();
      bus.Load_Valid_In    = 1'b0;
      bus.Parallel_Data_In = 8'($urandom);
      chk("ign_line", 32'(bus.Serial_Data_Out), 32'd0);
    end
    tick();
    chk("ign_done",  32'(bus.Done_Out),  32'd1);
    chk("ign_frame", 32'(bus.Frame_Out), 32'd0);

    // 6: reset during bit 4 of 0xF0, then 0x81
    bus.Parallel_Data_In = 8'hF0;
    bus.Load_Valid_In    = 1'b1;
    tick();
    bus.Load_Valid_In = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    chk("f0_bit4", 32'(bus.Serial_Data_Out), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_line",  32'(bus.Serial_Data_Out), 32'd0);
    chk("mid_rst_frame", 32'(bus.Frame_Out),       32'd0);
    chk("mid_rst_busy",  32'(bus.Busy_Out),        32'd0);
    chk("mid_rst_ready", 32'(bus.Load_Ready_Out),  32'd1);
    nbits = 0;
    #1 rst = 1'b0;
    bus.Parallel_Data_In = 8'h81;
    bus.Load_Valid_In    = 1'b1;
    exp_q.push_back(8'h81);
    tick();
    bus.Load_Valid_In = 1'b0;
    chk("81_bit0", 32'(bus.Serial_Data_Out), 32'd1);
    for (int k = 1; k < 8; k++) tick();
    chk("sipo_81", 32'(sipo), 32'h81);
    tick();
    chk("81_done", 32'(bus.Done_Out), 32'd1);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
